pipe_ctrl: RTL

Central stall/flush controller for the dual-issue pipeline. It merges per-stage stall requests, memory-stage exceptions and EX-stage branch mispredicts into the `stall[3:0]`, `flush`, `flush_cause` and `new_pc` signals consumed by every pipeline register, including EX/MEM. A small FSM sequences exception entry: it defers the flush while the data cache is busy, then holds the front end for a refill window. A saturating counter reports stalled cycles for performance monitoring.

---
 rtl/pipe_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stall requests, exceptions and mispredicts into pipeline stall/flush/redirect controls
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE     = 32'h0000000E,
  parameter int unsigned REFILL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] exception_type_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        mispredict_i,
  input  logic [31:0] mispredict_target_i,
  output logic [3:0]  stall_o,
  output logic        flush_o,
  output logic        flush_cause_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cycles_o
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, REFILL} state_t;
  localparam logic [3:0] REFILL_INIT = 4'(REFILL_CYCLES);
  state_t      state_q, state_d;
  logic [3:0]  refill_cnt_q, refill_cnt_d;
  logic [31:0] exc_type_q, exc_type_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [3:0]  prefix;
  // hold every stage up to the highest one requesting a stall
  always_comb
    prefix = stallreq_mem_i ? 4'b0111 :
             stallreq_ex_i ? 4'b0011 :
             (stallreq_if_i | stallreq_id_i) ? 4'b0001 : 4'b0000;
  // sequencing: deferred exceptions win, then live exceptions, refill hold, mispredict redirect
  always_comb begin
    state_d       = state_q;
    refill_cnt_d  = refill_cnt_q;
    exc_type_d    = exc_type_q;
    epc_d         = epc_q;
    stall_o       = prefix;
    flush_o       = 1'b0;
    flush_cause_o = 1'b0;
    new_pc_o      = 32'h0;
    if (state_q == WAIT_MEM) begin
      if (stallreq_mem_i) stall_o = 4'hF;
      else begin
        stall_o       = 4'h0;
        flush_o       = 1'b1;
        flush_cause_o = 1'b1;
        new_pc_o      = (exc_type_q == ERET_CODE) ? epc_q : EXC_VECTOR;
        state_d       = REFILL;
        refill_cnt_d  = REFILL_INIT;
      end
    end else if (exception_type_i != 32'h0) begin
      if (stallreq_mem_i) begin
        stall_o    = 4'hF;
        exc_type_d = exception_type_i;
        epc_d      = cp0_epc_i;
        state_d    = WAIT_MEM;
      end else begin
        stall_o       = 4'h0;
        flush_o       = 1'b1;
        flush_cause_o = 1'b1;
        new_pc_o      = (exception_type_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
        state_d       = REFILL;
        refill_cnt_d  = REFILL_INIT;
      end
    end else if (state_q == REFILL) begin
      stall_o      = prefix | 4'b0001;
      refill_cnt_d = refill_cnt_q - 4'd1;
      state_d      = (refill_cnt_q == 4'd1) ? IDLE : REFILL;
    end else if (mispredict_i && !prefix[1]) begin
      flush_o  = 1'b1;
      new_pc_o = mispredict_target_i;
    end
  end
  // saturating count of stalled cycles
  always_comb stall_cnt_d = (|stall_o && !(&stall_cnt_q)) ? stall_cnt_q + 32'd1 : stall_cnt_q;
  // state, latched exception and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      refill_cnt_q <= 4'd0;
      exc_type_q   <= 32'h0;
      epc_q        <= 32'h0;
      stall_cnt_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      refill_cnt_q <= refill_cnt_d;
      exc_type_q   <= exc_type_d;
      epc_q        <= epc_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end
  assign stall_cycles_o = stall_cnt_q;
endmodule
